// File: rtl/vga_timing_gen_if.sv
// Pin bundle for the VGA timing generator: line-buffer read port, receive-side sync, video out.
// Latency: none (wires only).
// Backpressure: none; master drives video and address every pixel clock, slave never stalls.
interface vga_timing_gen_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              vga_sync;
    logic              vga_sync_en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] vga_r;
    logic [DATA_W-1:0] vga_g;
    logic [DATA_W-1:0] vga_b;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_visible;
    logic              frame_start;
    logic              locked;

    // Generator side
    modport master (
        output bram_addr,
        input  bram_dout,
        input  vga_sync,
        input  vga_sync_en,
        input  mode,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hs,
        output vga_vs,
        output vga_visible,
        output frame_start,
        output locked
    );

    // Line buffer, receive side and display side
    modport slave (
        input  bram_addr,
        output bram_dout,
        output vga_sync,
        output vga_sync_en,
        output mode,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hs,
        input  vga_vs,
        input  vga_visible,
        input  frame_start,
        input  locked
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing with line-buffer fetch, test patterns and lock to a receive-side frame pulse.
// Latency: every video output lags the h/v counters by RD_LAT+2 pixel clocks.
// Backpressure: none; free-running pixel stream, the line buffer is read unconditionally.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 5 bits so the grid pattern can always look at [4:0]
    localparam int H_W = ($clog2(H_TOTAL + 1) < 5) ? 5 : $clog2(H_TOTAL + 1);
    localparam int V_W = ($clog2(V_TOTAL + 1) < 5) ? 5 : $clog2(V_TOTAL + 1);
    // Control stages that travel alongside the BRAM read; the colour register is the last stage
    localparam int P = RD_LAT + 1;

    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG    = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG    = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic       vis;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       grid;
        logic [2:0] bar;
        logic [1:0] mode;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{vis: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0,
                                  grid: 1'b0, bar: 3'd0, mode: 2'd0};

    // First h of colour bar k: smallest h with h*8/H_ACTIVE >= k
    function automatic logic [H_W-1:0] bar_edge(input int k);
        return H_W'((k * H_ACTIVE + 7) / 8);
    endfunction

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           sync_hit;
    logic           h_end;
    logic           at_end;
    logic           frame_top;
    logic [1:0]     missed;
    logic           locked_q;
    logic [1:0]     mode_q;
    logic [1:0]     mode_cur;
    ctl_t           cur;
    ctl_t           pipe [P];
    ctl_t           tail;
    logic [DATA_W-1:0] r_nxt;
    logic [DATA_W-1:0] g_nxt;
    logic [DATA_W-1:0] b_nxt;

    assign sync_hit  = bus.vga_sync_en & bus.vga_sync;
    assign h_end     = (h == H_LAST);
    assign at_end    = h_end && (v == V_LAST);
    assign frame_top = (h == '0) && (v == '0);
    // Mode only changes at the frame origin, so pixel (0,0) already sees the new value
    assign mode_cur  = frame_top ? bus.mode : mode_q;
    assign tail      = pipe[P-1];
    assign bus.locked = locked_q;

    // Raster counters; an enabled sync pulse reloads the origin over the normal advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (sync_hit) begin
            h <= '0;
            v <= '0;
        end else if (h_end) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Lock tracking: aligned pulse lands exactly on the natural wrap; two pulse-less wraps drop lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed   <= 2'd0;
            locked_q <= 1'b0;
        end else begin
            if (sync_hit)
                missed <= 2'd0;
            else if (at_end && (missed != 2'd2))
                missed <= missed + 2'd1;

            if (!bus.vga_sync_en)
                locked_q <= 1'b0;
            else if (sync_hit)
                locked_q <= at_end;
            else if (at_end && (missed != 2'd0))
                locked_q <= 1'b0;
        end
    end

    // Hold the pattern selection for the rest of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 2'd0;
        else        mode_q <= mode_cur;
    end

    // Decode region, pattern inputs and frame marker from the current counters
    always_comb begin
        cur      = CTL_IDLE;
        cur.vis  = (h < H_VIS_END) && (v < V_VIS_END);
        cur.hs   = ((h >= HS_BEG) && (h < HS_END)) ? HS_POL : ~HS_POL;
        cur.vs   = ((v >= VS_BEG) && (v < VS_END)) ? VS_POL : ~VS_POL;
        cur.fs   = frame_top;
        cur.grid = (h[4:0] == 5'd0) || (v[4:0] == 5'd0);
        cur.mode = mode_cur;
        for (int k = 1; k < 8; k++) begin
            if (h >= bar_edge(k)) cur.bar = cur.bar + 3'd1;
        end
    end

    // Issue the line-buffer read and carry control beside it; sync reload never flushes this
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P; i++) pipe[i] <= CTL_IDLE;
            bus.bram_addr <= '0;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < P; i++) pipe[i] <= pipe[i-1];
            bus.bram_addr <= cur.vis ? ADDR_W'(h) : '0;
        end
    end

    // Pixel source select; blanking forces black whatever the mode
    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (tail.vis) begin
            case (tail.mode)
                2'd0: begin
                    r_nxt = bus.bram_dout;
                    g_nxt = bus.bram_dout;
                    b_nxt = bus.bram_dout;
                end
                2'd1: begin
                    // white, yellow, cyan, green, magenta, red, blue, black
                    r_nxt = {DATA_W{~tail.bar[1]}};
                    g_nxt = {DATA_W{~tail.bar[2]}};
                    b_nxt = {DATA_W{~tail.bar[0]}};
                end
                2'd2: begin
                    r_nxt = {DATA_W{tail.grid}};
                    g_nxt = {DATA_W{tail.grid}};
                    b_nxt = {DATA_W{tail.grid}};
                end
                default: g_nxt = '1;
            endcase
        end
    end

    // Output register: colour and the delayed syncs leave together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= ~HS_POL;
            bus.vga_vs      <= ~VS_POL;
            bus.vga_visible <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.vga_r       <= r_nxt;
            bus.vga_g       <= g_nxt;
            bus.vga_b       <= b_nxt;
            bus.vga_hs      <= tail.hs;
            bus.vga_vs      <= tail.vs;
            bus.vga_visible <= tail.vis;
            bus.frame_start <= tail.fs;
        end
    end
endmodule
